// File: rtl/bram_arb_pkg.sv
// Shared types and the round-robin pick helper for BRAM port arbiters.
package bram_arb_pkg;

    localparam int MaxReq      = 8;
    localparam int MaxPtrWidth = $clog2(MaxReq);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Rotate-priority search: the first valid bit at or above ptr wins,
    // wrapping at num_req. Returns a one-hot vector (all zero if nothing valid).
    // ptr is expected to be below num_req, so one subtraction is enough to wrap.
    function automatic logic [MaxReq-1:0] rr_pick(
        input logic [MaxReq-1:0]      valid,
        input logic [MaxPtrWidth-1:0] ptr,
        input int unsigned            num_req
    );
        logic [MaxReq-1:0] grant;
        logic              found;
        logic [31:0]       idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MaxReq; k++) begin
            idx = 32'(ptr) + 32'(k);
            if (idx >= 32'(num_req)) begin
                idx = idx - 32'(num_req);
            end
            if ((k < num_req) && !found && valid[idx[MaxPtrWidth-1:0]]) begin
                grant[idx[MaxPtrWidth-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/bram_arb_rr_picker.sv
// Combinational rotate-priority encoder; shared by the arbiters that front
// single-ported resources.
module bram_arb_rr_picker
    import bram_arb_pkg::*;
#(
    parameter int NumReq   = 4,
    parameter int PtrWidth = $clog2(NumReq)
) (
    input  logic [NumReq-1:0]   valid_i,
    input  logic [PtrWidth-1:0] ptr_i,
    output logic [NumReq-1:0]   grant_o
);

    // Widen to the package's fixed search width, then trim back to NumReq.
    always_comb begin
        grant_o = NumReq'(rr_pick(MaxReq'(valid_i), MaxPtrWidth'(ptr_i), NumReq));
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NumReq requesters, with a
// per-requester lock for bursts and a one-cycle read response pipeline.
// Optional build macro: BRAM_ARB_STATS_EN adds per-requester grant and stall
// counters (saturating, 32 bits each).
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NumReq    = 4,
    parameter int DataWidth = 16,
    parameter int Depth     = 1024,
    parameter int AddrWidth = $clog2(Depth + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq-1:0]             req_write_i,
    input  logic [NumReq-1:0]             req_lock_i,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq*DataWidth-1:0]   req_data_i,
    output logic [NumReq-1:0]             rsp_valid_o,
    output logic [DataWidth-1:0]          rsp_data_o,
    output logic                          mem_write_en_o,
    output logic [AddrWidth-1:0]          mem_addr_o,
    output logic [DataWidth-1:0]          mem_data_o,
    input  logic [DataWidth-1:0]          mem_data_i
`ifdef BRAM_ARB_STATS_EN
    ,
    output logic [NumReq*32-1:0]          stat_grant_cnt_o,
    output logic [NumReq*32-1:0]          stat_stall_cnt_o
`endif
);

    localparam int PtrWidth = $clog2(NumReq);

    arb_state_e            state_q, state_d;
    logic [PtrWidth-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PtrWidth-1:0]   lock_owner_q, lock_owner_d;
    logic                  rsp_pending_q, rsp_pending_d;
    logic [PtrWidth-1:0]   rsp_owner_q, rsp_owner_d;
    logic [AddrWidth-1:0]  mem_addr_q, mem_addr_d;

    logic [NumReq-1:0]     rr_grant;
    logic [NumReq-1:0]     grant;
    logic                  accept;
    logic [PtrWidth-1:0]   grant_idx;
    logic [PtrWidth-1:0]   grant_next_ptr;

    bram_arb_rr_picker #(
        .NumReq   (NumReq),
        .PtrWidth (PtrWidth)
    ) u_picker (
        .valid_i (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (rr_grant)
    );

    // Grant selection: rotating pick when idle, only the owner when locked, nothing in reset.
    always_comb begin
        grant = '0;
        if (!rst_i) begin
            case (state_q)
                IDLE:    grant = rr_grant;
                LOCKED:  grant[lock_owner_q] = req_valid_i[lock_owner_q];
                default: grant = '0;
            endcase
        end
    end

    // One-hot grant to index, plus the wrapped successor used as the next pointer.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (grant[i]) begin
                grant_idx = PtrWidth'(i);
            end
        end
        accept = |grant;
        if (grant_idx == PtrWidth'(NumReq - 1)) begin
            grant_next_ptr = '0;
        end else begin
            grant_next_ptr = grant_idx + 1'b1;
        end
    end

    // Next state: every accept moves the pointer past the winner; its lock bit decides LOCKED vs IDLE.
    // While locked the winner is always the owner, so releasing leaves the pointer at owner+1.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        lock_owner_d  = lock_owner_q;
        rsp_pending_d = accept && !req_write_i[grant_idx];
        rsp_owner_d   = grant_idx;
        if (accept) begin
            rr_ptr_d = grant_next_ptr;
            if (req_lock_i[grant_idx]) begin
                state_d      = LOCKED;
                lock_owner_d = grant_idx;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // BRAM drive: mux the winner's fields; with no winner hold the address so reads stay quiet.
    always_comb begin
        mem_write_en_o = 1'b0;
        mem_addr_o     = mem_addr_q;
        mem_data_o     = '0;
        if (accept) begin
            mem_write_en_o = req_write_i[grant_idx];
            mem_addr_o     = req_addr_i[int'(grant_idx)*AddrWidth +: AddrWidth];
            mem_data_o     = req_data_i[int'(grant_idx)*DataWidth +: DataWidth];
        end
        mem_addr_d = mem_addr_o;
    end

    // Response strobe for the read accepted last cycle; a reset in this cycle swallows it.
    always_comb begin
        req_ready_o = grant;
        rsp_valid_o = '0;
        if (rsp_pending_q && !rst_i) begin
            rsp_valid_o[rsp_owner_q] = 1'b1;
        end
        rsp_data_o = mem_data_i;
    end

    // State, pointer and response pipeline registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            lock_owner_q  <= '0;
            rsp_pending_q <= 1'b0;
            rsp_owner_q   <= '0;
            mem_addr_q    <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            lock_owner_q  <= lock_owner_d;
            rsp_pending_q <= rsp_pending_d;
            rsp_owner_q   <= rsp_owner_d;
            mem_addr_q    <= mem_addr_d;
        end
    end

`ifdef BRAM_ARB_STATS_EN
    logic [31:0] grant_cnt_q [NumReq];
    logic [31:0] grant_cnt_d [NumReq];
    logic [31:0] stall_cnt_q [NumReq];
    logic [31:0] stall_cnt_d [NumReq];

    // Saturating counters: accepted requests, and cycles spent waiting with valid high.
    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i];
            stall_cnt_d[i] = stall_cnt_q[i];
            if (grant[i] && (grant_cnt_q[i] != '1)) begin
                grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
            end
            if (req_valid_i[i] && !grant[i] && (stall_cnt_q[i] != '1)) begin
                stall_cnt_d[i] = stall_cnt_q[i] + 32'd1;
            end
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumReq; i++) begin
            if (rst_i) begin
                grant_cnt_q[i] <= '0;
                stall_cnt_q[i] <= '0;
            end else begin
                grant_cnt_q[i] <= grant_cnt_d[i];
                stall_cnt_q[i] <= stall_cnt_d[i];
            end
        end
    end

    // Flatten the counters onto the packed stat ports.
    always_comb begin
        for (int i = 0; i < NumReq; i++) begin
            stat_grant_cnt_o[i*32 +: 32] = grant_cnt_q[i];
            stat_stall_cnt_o[i*32 +: 32] = stall_cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Scoreboard bench for bram_port_arbiter: a behavioural arbiter model predicts
// grants and BRAM drive each cycle and queues expected read responses; an
// independent monitor pops the queue whenever a response strobe shows up.
module tb_bram_port_arbiter;

    localparam int NumReq    = 4;
    localparam int DataWidth = 16;
    localparam int Depth     = 1024;
    localparam int AddrWidth = $clog2(Depth + 1);

    logic                        clk = 1'b0;
    logic                        rst;
    logic [NumReq-1:0]           req_valid, req_ready, req_write, req_lock, rsp_valid;
    logic [NumReq*AddrWidth-1:0] req_addr;
    logic [NumReq*DataWidth-1:0] req_data;
    logic [DataWidth-1:0]        rsp_data, mem_wdata, mem_rdata;
    logic [AddrWidth-1:0]        mem_addr;
    logic                        mem_we;
`ifdef BRAM_ARB_STATS_EN
    logic [NumReq*32-1:0]        stat_grant, stat_stall;
`endif

    always #5 clk = ~clk;

    bram_port_arbiter #(
        .NumReq    (NumReq),
        .DataWidth (DataWidth),
        .Depth     (Depth),
        .AddrWidth (AddrWidth)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_write_i    (req_write),
        .req_lock_i     (req_lock),
        .req_addr_i     (req_addr),
        .req_data_i     (req_data),
        .rsp_valid_o    (rsp_valid),
        .rsp_data_o     (rsp_data),
        .mem_write_en_o (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_data_o     (mem_wdata),
        .mem_data_i     (mem_rdata)
`ifdef BRAM_ARB_STATS_EN
        ,
        .stat_grant_cnt_o (stat_grant),
        .stat_stall_cnt_o (stat_stall)
`endif
    );

    // BRAM port model: synchronous write, registered read-first data.
    logic [DataWidth-1:0] bram [Depth];
    always @(posedge clk) begin
        if (mem_we) bram[mem_addr[AddrWidth-2:0]] <= mem_wdata;
        mem_rdata <= bram[mem_addr[AddrWidth-2:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Requester-side stimulus state.
    bit                   v [NumReq];
    bit                   w [NumReq];
    bit                   l [NumReq];
    logic [AddrWidth-1:0] a [NumReq];
    logic [DataWidth-1:0] d [NumReq];

    // Reference model state: the arbitration rules and memory contents.
    int                   m_ptr = 0;
    bit                   m_locked = 0;
    int                   m_owner = 0;
    logic [AddrWidth-1:0] m_last_addr;
    bit                   m_last_valid = 0;
    logic [DataWidth-1:0] shadow [Depth];
    longint               s_grant [NumReq];
    longint               s_stall [NumReq];

    typedef struct {
        int                   owner;
        logic [DataWidth-1:0] data;
        int                   due;
    } rsp_t;
    rsp_t rsp_q [$];
    rsp_t mon_e;

    int n_cmp  = 0;
    int n_fail = 0;
    int g;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Who should win this cycle, from the arbitration rules alone.
    function automatic int modelGrant();
        if (m_locked) return v[m_owner] ? m_owner : -1;
        for (int k = 0; k < NumReq; k++) begin
            if (v[(m_ptr + k) % NumReq]) return (m_ptr + k) % NumReq;
        end
        return -1;
    endfunction

    // Drive one cycle (called at posedge+1), check the combinational outputs
    // mid-cycle, then advance the model at the next posedge+1.
    task automatic applyStimulus(input bit rstv, output int gr);
        rst = rstv;
        for (int i = 0; i < NumReq; i++) begin
            req_valid[i] = v[i];
            req_write[i] = w[i];
            req_lock[i]  = l[i];
            req_addr[i*AddrWidth +: AddrWidth] = a[i];
            req_data[i*DataWidth +: DataWidth] = d[i];
        end
        if (rstv) rsp_q.delete();
        gr = rstv ? -1 : modelGrant();
        @(negedge clk);
        checkOutput("req_ready", 64'(req_ready), (gr >= 0) ? 64'(1 << gr) : 64'd0);
        checkOutput("mem_write_en", 64'(mem_we), (gr >= 0) ? 64'(w[gr]) : 64'd0);
        if (gr >= 0) begin
            checkOutput("mem_addr", 64'(mem_addr), 64'(a[gr]));
            if (w[gr]) checkOutput("mem_data", 64'(mem_wdata), 64'(d[gr]));
        end else if (m_last_valid) begin
            checkOutput("mem_addr_hold", 64'(mem_addr), 64'(m_last_addr));
        end
        @(posedge clk);
        #1;
        if (rstv) begin
            m_ptr = 0; m_locked = 0; m_owner = 0; m_last_valid = 0;
            for (int i = 0; i < NumReq; i++) begin s_grant[i] = 0; s_stall[i] = 0; end
        end else begin
            for (int i = 0; i < NumReq; i++) if (v[i] && i != gr) s_stall[i]++;
            if (gr >= 0) begin
                s_grant[gr]++;
                m_ptr = (gr + 1) % NumReq;
                m_locked = l[gr];
                if (l[gr]) m_owner = gr;
                m_last_addr  = a[gr];
                m_last_valid = 1;
                if (w[gr]) shadow[int'(a[gr])] = d[gr];
                else rsp_q.push_back('{gr, shadow[int'(a[gr])], cyc});
            end
        end
    endtask

    task automatic newRequest(input int i);
        v[i] = 1;
        w[i] = 1'($urandom_range(1));
        l[i] = ($urandom_range(3) == 0);
        a[i] = AddrWidth'($urandom_range(31));
        d[i] = DataWidth'($urandom);
    endtask

    task automatic setReq(input int i, input bit wr, input bit lk, input int addr, input int data);
        v[i] = 1; w[i] = wr; l[i] = lk;
        a[i] = AddrWidth'(addr); d[i] = DataWidth'(data);
    endtask

    task automatic idleAll();
        for (int i = 0; i < NumReq; i++) v[i] = 0;
    endtask

    // Monitor: every strobe must match the oldest queued read; a due read with no strobe is a miss.
    always @(negedge clk) begin
        if (rsp_valid !== '0) begin
            if (rsp_q.size() == 0) begin
                checkOutput("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                mon_e = rsp_q.pop_front();
                checkOutput("rsp_valid", 64'(rsp_valid), 64'(1 << mon_e.owner));
                checkOutput("rsp_data", 64'(rsp_data), 64'(mon_e.data));
                checkOutput("rsp_cycle", 64'(cyc), 64'(mon_e.due));
            end
        end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            checkOutput("rsp_missing", 64'(rsp_valid), 64'(1 << rsp_q[0].owner));
            void'(rsp_q.pop_front());
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0; req_write = '0; req_lock = '0; req_addr = '0; req_data = '0;
        for (int i = 0; i < Depth; i++) begin bram[i] = '0; shadow[i] = '0; end
        for (int i = 0; i < NumReq; i++) begin
            v[i] = 0; w[i] = 0; l[i] = 0; a[i] = '0; d[i] = '0; s_grant[i] = 0; s_stall[i] = 0;
        end
        @(posedge clk);
        #1;

        // Reset with everyone valid: no grants, no writes.
        for (int i = 0; i < NumReq; i++) setReq(i, 1, 0, i, 16'hAAAA);
        applyStimulus(1, g);
        applyStimulus(1, g);
        idleAll();

        // Single read: requester 2 writes 0xBEEF to 0x010 then reads it back.
        setReq(2, 1, 0, 'h010, 'hBEEF);
        applyStimulus(0, g);
        idleAll();
        applyStimulus(0, g);
        setReq(2, 0, 0, 'h010, 0);
        applyStimulus(0, g);
        idleAll();
        applyStimulus(0, g);

        // Contention: all four hold reads at 0..3 for five cycles.
        for (int i = 0; i < NumReq; i++) setReq(i, 0, 0, i, 0);
        repeat (5) applyStimulus(0, g);
        idleAll();
        applyStimulus(0, g);

        // Lock burst: requester 1 writes three times (lock 1,1,0) while 0 and 3 wait.
        setReq(0, 0, 0, 'h010, 0);
        setReq(3, 0, 0, 'h002, 0);
        for (int k = 0; k < 3; k++) begin
            setReq(1, 1, (k < 2), 'h020 + k, 'h1000 + k);
            applyStimulus(0, g);
        end
        v[1] = 0;
        repeat (3) begin
            applyStimulus(0, g);
            if (g >= 0) v[g] = 0;
        end

        // Owner goes quiet while locked; requester 2 must wait until the lock is released.
        setReq(0, 0, 1, 'h005, 0);
        applyStimulus(0, g);
        v[0] = 0;
        setReq(2, 0, 0, 'h020, 0);
        repeat (5) applyStimulus(0, g);
        setReq(0, 0, 0, 'h006, 0);
        applyStimulus(0, g);
        v[0] = 0;
        applyStimulus(0, g);
        idleAll();
        applyStimulus(0, g);

        // Reset while locked with a read in flight, then a fresh request from 3.
        setReq(1, 0, 1, 'h021, 0);
        applyStimulus(0, g);
        idleAll();
        applyStimulus(1, g);
        setReq(3, 0, 0, 'h010, 0);
        applyStimulus(0, g);
        idleAll();
        applyStimulus(0, g);

        // Randomised traffic with occasional drops and resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NumReq; i++) begin
                if (!v[i] && $urandom_range(1) == 1) newRequest(i);
                else if (v[i] && $urandom_range(99) < 5) v[i] = 0;
            end
            applyStimulus(($urandom_range(99) < 2), g);
            if (g >= 0) v[g] = 0;
        end

        // Drain and confirm every queued read was answered.
        idleAll();
        repeat (4) applyStimulus(0, g);
        checkOutput("rsp_queue_empty", 64'(rsp_q.size()), 64'd0);

`ifdef BRAM_ARB_STATS_EN
        // Stats: eight cycles with 0 and 1 always valid after a clean reset.
        applyStimulus(1, g);
        setReq(0, 0, 0, 'h001, 0);
        setReq(1, 0, 0, 'h002, 0);
        repeat (8) applyStimulus(0, g);
        idleAll();
        applyStimulus(0, g);
        for (int i = 0; i < NumReq; i++) begin
            checkOutput("stat_grant", 64'(stat_grant[i*32 +: 32]), 64'(s_grant[i]));
            checkOutput("stat_stall", 64'(stat_stall[i*32 +: 32]), 64'(s_stall[i]));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
